// File: rtl/spilling_uc.sv
// Control unit for the three-sensor ultrasonic measure-and-report cycle.
// Measures all sensors once, then transmits 3 sensors x 4 characters over the serial link.
package spilling_uc_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'd0,
        ST_PREPARACAO     = 4'd1,
        ST_ESPERA         = 4'd2,
        ST_MEDE           = 4'd3,
        ST_AGUARDA_MEDIDA = 4'd4,
        ST_CARREGA        = 4'd5,
        ST_TRANSMITE      = 4'd6,
        ST_ESPERA_TX      = 4'd7,
        ST_PROXIMO_CHAR   = 4'd8,
        ST_PROXIMO_SENSOR = 4'd9,
        ST_FIM            = 4'd10
    } state_t;

    typedef struct packed {
        logic zera_sensor;
        logic zera_serial;
        logic zera_seg;
        logic zera_2;
        logic zera_3;
        logic zera_disc;
        logic zera_servos;
        logic cont_seg;
        logic cont_2;
        logic cont_3;
        logic medir;
        logic partida_tx;
        logic carrega_disc;
        logic fim_ciclo;
    } ctrl_t;

endpackage

module spilling_uc
    import spilling_uc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_seg,
    input  logic       pronto_serial,
    input  logic [1:0] Q_2,
    input  logic [1:0] Q_3,
    output logic       zera_sensor,
    output logic       zera_serial,
    output logic       zera_seg,
    output logic       zera_2,
    output logic       zera_3,
    output logic       zera_disc,
    output logic       zera_servos,
    output logic       cont_seg,
    output logic       cont_2,
    output logic       cont_3,
    output logic       medir,
    output logic       partida_tx,
    output logic       carrega_disc,
    output logic       fim_ciclo,
    output logic [3:0] db_estado
);

    state_t state_r;
    state_t next_s;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_r;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_INICIAL;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; unused codes fall back to inicial
    always_comb begin
        next_s = ST_INICIAL;
        case (state_r)
            ST_INICIAL:        next_s = ligar ? ST_PREPARACAO : ST_INICIAL;
            ST_PREPARACAO:     next_s = ST_ESPERA;
            ST_ESPERA: begin
                if (!ligar) begin
                    next_s = ST_INICIAL;
                end else if (pronto_seg) begin
                    next_s = ST_MEDE;
                end else begin
                    next_s = ST_ESPERA;
                end
            end
            ST_MEDE:           next_s = ST_AGUARDA_MEDIDA;
            ST_AGUARDA_MEDIDA: next_s = pronto_seg ? ST_CARREGA : ST_AGUARDA_MEDIDA;
            ST_CARREGA:        next_s = ST_TRANSMITE;
            ST_TRANSMITE:      next_s = ST_ESPERA_TX;
            ST_ESPERA_TX:      next_s = pronto_serial ? ST_PROXIMO_CHAR : ST_ESPERA_TX;
            ST_PROXIMO_CHAR: begin
                if (Q_3 != 2'd3) begin
                    next_s = ST_TRANSMITE;
                end else if (Q_2 != 2'd2) begin
                    next_s = ST_PROXIMO_SENSOR;
                end else begin
                    next_s = ST_FIM;
                end
            end
            ST_PROXIMO_SENSOR: next_s = ST_TRANSMITE;
            ST_FIM:            next_s = ligar ? ST_ESPERA : ST_INICIAL;
            default:           next_s = ST_INICIAL;
        endcase
    end

    // Output decode of the upcoming state, so registered outputs line up with state_r
    always_comb begin
        ctrl_s = '0;
        case (next_s)
            ST_PREPARACAO: begin
                ctrl_s.zera_sensor = 1'b1;
                ctrl_s.zera_serial = 1'b1;
                ctrl_s.zera_seg    = 1'b1;
                ctrl_s.zera_2      = 1'b1;
                ctrl_s.zera_3      = 1'b1;
                ctrl_s.zera_disc   = 1'b1;
                ctrl_s.zera_servos = 1'b1;
            end
            ST_ESPERA:         ctrl_s.cont_seg = 1'b1;
            ST_MEDE: begin
                ctrl_s.medir    = 1'b1;
                ctrl_s.zera_seg = 1'b1;
            end
            ST_AGUARDA_MEDIDA: ctrl_s.cont_seg = 1'b1;
            ST_CARREGA: begin
                ctrl_s.carrega_disc = 1'b1;
                ctrl_s.zera_2       = 1'b1;
                ctrl_s.zera_3       = 1'b1;
                ctrl_s.zera_seg     = 1'b1;
            end
            ST_TRANSMITE:      ctrl_s.partida_tx = 1'b1;
            ST_PROXIMO_CHAR:   ctrl_s.cont_3 = 1'b1;
            ST_PROXIMO_SENSOR: ctrl_s.cont_2 = 1'b1;
            ST_FIM: begin
                ctrl_s.fim_ciclo = 1'b1;
                ctrl_s.zera_seg  = 1'b1;
            end
            default:           ctrl_s = '0;
        endcase
    end

    // Output register, cleared together with the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_r <= '0;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign zera_sensor  = ctrl_r.zera_sensor;
    assign zera_serial  = ctrl_r.zera_serial;
    assign zera_seg     = ctrl_r.zera_seg;
    assign zera_2       = ctrl_r.zera_2;
    assign zera_3       = ctrl_r.zera_3;
    assign zera_disc    = ctrl_r.zera_disc;
    assign zera_servos  = ctrl_r.zera_servos;
    assign cont_seg     = ctrl_r.cont_seg;
    assign cont_2       = ctrl_r.cont_2;
    assign cont_3       = ctrl_r.cont_3;
    assign medir        = ctrl_r.medir;
    assign partida_tx   = ctrl_r.partida_tx;
    assign carrega_disc = ctrl_r.carrega_disc;
    assign fim_ciclo    = ctrl_r.fim_ciclo;
    assign db_estado    = state_r;

endmodule

// File: tb/tb_spilling_uc.sv
// Bench for spilling_uc: state-level reference model, datapath counters and a
// serial responder that replies 5 clocks after each transmit start.
module tb_spilling_uc;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       pronto_seg;
    logic       pronto_serial;
    logic [1:0] Q_2;
    logic [1:0] Q_3;
    logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_disc, zera_servos;
    logic       cont_seg, cont_2, cont_3, medir, partida_tx, carrega_disc, fim_ciclo;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int m     = 0;
    bit chk_en = 1'b0;
    int n_ptx = 0, n_c2 = 0, n_c3 = 0, n_med = 0, n_cd = 0, n_fc = 0;

    wire [13:0] dut_out = {zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_disc, zera_servos,
                           cont_seg, cont_2, cont_3, medir, partida_tx, carrega_disc, fim_ciclo};

    always #5 clock = ~clock;

    spilling_uc dut (
        .clock(clock), .reset(reset), .ligar(ligar), .pronto_seg(pronto_seg),
        .pronto_serial(pronto_serial), .Q_2(Q_2), .Q_3(Q_3),
        .zera_sensor(zera_sensor), .zera_serial(zera_serial), .zera_seg(zera_seg),
        .zera_2(zera_2), .zera_3(zera_3), .zera_disc(zera_disc), .zera_servos(zera_servos),
        .cont_seg(cont_seg), .cont_2(cont_2), .cont_3(cont_3), .medir(medir),
        .partida_tx(partida_tx), .carrega_disc(carrega_disc), .fim_ciclo(fim_ciclo),
        .db_estado(db_estado)
    );

    // Required outputs per state code, bit order as dut_out
    function automatic logic [13:0] exp_out(input int s);
        case (s)
            1:       return 14'b1111111_0000000;
            2:       return 14'b0000000_1000000;
            3:       return 14'b0010000_0001000;
            4:       return 14'b0000000_1000000;
            5:       return 14'b0011100_0000010;
            6:       return 14'b0000000_0000100;
            8:       return 14'b0000000_0010000;
            9:       return 14'b0000000_0100000;
            10:      return 14'b0010000_0000001;
            default: return 14'b0000000_0000000;
        endcase
    endfunction

    function automatic int nxt(input int s);
        if (s == 0)  return ligar ? 1 : 0;
        if (s == 1)  return 2;
        if (s == 2)  return !ligar ? 0 : (pronto_seg ? 3 : 2);
        if (s == 3)  return 4;
        if (s == 4)  return pronto_seg ? 5 : 4;
        if (s == 5)  return 6;
        if (s == 6)  return 7;
        if (s == 7)  return pronto_serial ? 8 : 7;
        if (s == 8)  return (Q_3 != 2'd3) ? 6 : ((Q_2 == 2'd2) ? 10 : 9);
        if (s == 9)  return 6;
        if (s == 10) return ligar ? 2 : 0;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (db_estado == 4'(code)) begin
                check(name, int'(db_estado), code);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: timeout, state %0d expected %0d", name, db_estado, code);
    endtask

    task automatic clear_counts();
        n_ptx = 0; n_c2 = 0; n_c3 = 0; n_med = 0; n_cd = 0; n_fc = 0;
    endtask

    task automatic measure();
        pronto_seg = 1'b1;
        @(negedge clock);
        pronto_seg = 1'b0;
        @(negedge clock);
        pronto_seg = 1'b1;
        @(negedge clock);
        pronto_seg = 1'b0;
    endtask

    // Reference model state
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) m = 0;
        else        m = nxt(m);
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            total++;
            if ({dut_out, db_estado} !== {exp_out(m), 4'(m)}) begin
                bad++;
                $display("FAIL model: got state %0d outs %b expected state %0d outs %b",
                         db_estado, dut_out, m, exp_out(m));
            end
        end
    end

    // Datapath counters, serial responder and pulse counting
    initial begin
        logic z2, z3, c2, c3, ptx, rst_v;
        int cd;
        cd = 0;
        Q_2 = 2'd0;
        Q_3 = 2'd0;
        pronto_serial = 1'b0;
        forever begin
            @(posedge clock);
            z2 = zera_2; z3 = zera_3; c2 = cont_2; c3 = cont_3; ptx = partida_tx; rst_v = reset;
            if (rst_v) begin
                n_ptx += int'(partida_tx); n_c2 += int'(cont_2); n_c3 += int'(cont_3);
                n_med += int'(medir); n_cd += int'(carrega_disc); n_fc += int'(fim_ciclo);
            end
            #1;
            pronto_serial = 1'b0;
            if (!rst_v) begin
                Q_2 = 2'd0;
                Q_3 = 2'd0;
                cd = 0;
            end else begin
                if (z2)      Q_2 = 2'd0;
                else if (c2) Q_2 = (Q_2 == 2'd2) ? 2'd0 : 2'(Q_2 + 2'd1);
                if (z3)      Q_3 = 2'd0;
                else if (c3) Q_3 = 2'(Q_3 + 2'd1);
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) pronto_serial = 1'b1;
                end
                if (ptx) cd = 5;
            end
        end
    end

    initial begin
        reset = 1'b0;
        ligar = 1'b0;
        pronto_seg = 1'b0;
        @(negedge clock);
        check("rst_state", int'(db_estado), 0);
        check("rst_outs", int'(dut_out), 0);
        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clock);
        check("idle_state", int'(db_estado), 0);
        ligar = 1'b1;
        @(negedge clock);
        check("prep_state", int'(db_estado), 1);
        check("prep_zera", int'(dut_out[13:7]), 127);
        @(negedge clock);
        check("espera_state", int'(db_estado), 2);
        check("espera_zera_off", int'(dut_out[13:7]), 0);

        // Full cycle with ligar held high
        clear_counts();
        pronto_seg = 1'b1;
        @(negedge clock);
        pronto_seg = 1'b0;
        check("mede_state", int'(db_estado), 3);
        check("mede_medir", int'(medir), 1);
        check("mede_zera_seg", int'(zera_seg), 1);
        @(negedge clock);
        check("aguarda_state", int'(db_estado), 4);
        check("aguarda_cont_seg", int'(cont_seg), 1);
        check("aguarda_medir_off", int'(medir), 0);
        @(negedge clock);
        pronto_seg = 1'b1;
        @(negedge clock);
        pronto_seg = 1'b0;
        check("carrega_state", int'(db_estado), 5);
        check("carrega_disc", int'(carrega_disc), 1);
        wait_state(10, 400, "reach_fim");
        @(negedge clock);
        check("fim_to_espera", int'(db_estado), 2);
        check("cnt_partida_tx", n_ptx, 12);
        check("cnt_cont_2", n_c2, 2);
        check("cnt_cont_3", n_c3, 12);
        check("cnt_fim_ciclo", n_fc, 1);
        check("cnt_medir", n_med, 1);
        check("cnt_carrega", n_cd, 1);

        // ligar dropped during transmission: cycle completes, then inicial
        clear_counts();
        measure();
        wait_state(7, 50, "reach_espera_tx");
        ligar = 1'b0;
        wait_state(10, 400, "reach_fim_2");
        @(negedge clock);
        check("fim_to_inicial", int'(db_estado), 0);
        check("cnt2_partida_tx", n_ptx, 12);
        check("cnt2_fim_ciclo", n_fc, 1);

        // ligar dropped in espera
        ligar = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("espera_again", int'(db_estado), 2);
        ligar = 1'b0;
        @(negedge clock);
        check("espera_ligar_off", int'(db_estado), 0);

        // Asynchronous reset in the middle of a transmission
        ligar = 1'b1;
        @(negedge clock);
        @(negedge clock);
        measure();
        wait_state(7, 50, "reach_espera_tx_3");
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", int'(db_estado), 0);
        check("async_rst_outs", int'(dut_out), 0);
        ligar = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear_counts();
        repeat (10) @(negedge clock);
        check("no_tx_after_rst", n_ptx, 0);
        check("no_fim_after_rst", n_fc, 0);

        // Illegal state code recovery
        ligar = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("espera_before_force", int'(db_estado), 2);
        chk_en = 1'b0;
        #1;
        force dut.state_r = spilling_uc_pkg::state_t'(4'd13);
        m = 13;
        #1;
        check("forced_code", int'(db_estado), 13);
        release dut.state_r;
        ligar = 1'b0;
        @(posedge clock);
        #1;
        check("illegal_recover", int'(db_estado), 0);
        check("illegal_outs", int'(dut_out), 0);
        @(negedge clock);
        chk_en = 1'b1;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spilling_uc.md
SPILLING_UC -- requirements
Module: spilling_uc

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; forces state inicial while low.
REQ-004 ligar  input  1  operation enable; level-sensitive.
REQ-005 pronto_seg  input  1  measurement-window timer done (counter terminal count).
REQ-006 pronto_serial  input  1  serial transmitter finished current character.
REQ-007 Q_2  input  2  current sensor index, 0..2.
REQ-008 Q_3  input  2  current character index within a sensor frame, 0..3.
REQ-009 zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_disc, zera_servos  output  1 each  active-high clears for the datapath.
REQ-010 cont_seg, cont_2, cont_3  output  1 each  counter enables.
REQ-011 medir  output  1  start pulse to all three ultrasonic interfaces.
REQ-012 partida_tx  output  1  serial transmit start pulse.
REQ-013 carrega_disc  output  1  load pulse to the three discretizers.
REQ-014 fim_ciclo  output  1  one-cycle pulse marking completion of a full measure-and-report cycle.
REQ-015 db_estado  output  4  current state code.

Function
REQ-016 The block SHALL be a Moore FSM; every output SHALL be decoded from the registered state only.
REQ-017 States and codes: inicial 0, preparacao 1, espera 2, mede 3, aguarda_medida 4, carrega 5, transmite 6, espera_tx 7, proximo_char 8, proximo_sensor 9, fim 10.
REQ-018 inicial: all outputs 0; ligar=1 -> preparacao, else stay.
REQ-019 preparacao: all seven zera_* = 1; unconditional -> espera.
REQ-020 espera: cont_seg=1; ligar=0 -> inicial (priority); else pronto_seg=1 -> mede; else stay.
REQ-021 mede: medir=1, zera_seg=1, both for exactly one cycle; -> aguarda_medida.
REQ-022 aguarda_medida: cont_seg=1; pronto_seg=1 -> carrega; ligar is ignored here.
REQ-023 carrega: carrega_disc=1, zera_2=1, zera_3=1, zera_seg=1; -> transmite.
REQ-024 transmite: partida_tx=1 for one cycle; -> espera_tx.
REQ-025 espera_tx: all outputs 0; pronto_serial=1 -> proximo_char; else stay, with no timeout.
REQ-026 proximo_char: cont_3=1; transition decisions use the Q_2/Q_3 values sampled in this state.
REQ-026a proximo_char with Q_3!=3 -> transmite.
REQ-026b proximo_char with Q_3=3 and Q_2!=2 -> proximo_sensor.
REQ-026c proximo_char with Q_3=3 and Q_2=2 -> fim.
REQ-027 proximo_sensor: cont_2=1; -> transmite. Q_3 has already wrapped to 0 through the modulo-4 counter.
REQ-028 fim: fim_ciclo=1, zera_seg=1; ligar=1 -> espera, else -> inicial.
REQ-029 Each cycle SHALL transmit exactly 12 characters (3 sensors x 4), with exactly 12 partida_tx pulses.
REQ-030 Exactly one medir pulse and one carrega_disc pulse SHALL occur per cycle.
REQ-031 Unused state codes 11..15 SHALL go to inicial on the next clock.
REQ-032 A pronto_serial asserted outside espera_tx SHALL be ignored.
REQ-033 A pronto_seg asserted outside espera and aguarda_medida SHALL be ignored.

Reset
REQ-034 reset=0 SHALL immediately force the state to inicial, independent of clock, setting every output to 0 and db_estado to 0.
REQ-035 Reset deassertion SHALL take effect on the next rising clock edge.
REQ-036 Reset mid-transmission SHALL abandon the cycle; the block SHALL perform no partial completion.

Verification
REQ-037 Reset then ligar=1: db_estado follows 0 -> 1 -> 2, and all zera_* are high for exactly one cycle in state 1.
REQ-038 In espera, pulse pronto_seg: one-cycle medir and zera_seg pulse (state 3), then state 4 with cont_seg=1.
REQ-039 Full cycle with a pronto_serial model replying 5 clocks after each partida_tx: 12 partida_tx pulses.
REQ-039a In the same cycle: cont_2 pulses twice, cont_3 pulses 12 times, then one fim_ciclo pulse, then back to state 2.
REQ-040 ligar=0 while in espera: next state is inicial (0); ligar=0 during transmission: all 12 characters complete, then fim -> inicial.
REQ-041 Pull reset low in espera_tx (state 7) between clock edges: db_estado=0 and outputs 0 before the next edge; partida_tx remains 0 until a new cycle.
REQ-042 Force state code 13 through the bench: next clock gives db_estado=0.
